// File: rtl/pet_pkg.sv
// Shared definitions for the pet statistics engine: life-cycle state encoding
// and the stat clamp helper used by every stat lane.
package pet_pkg;

    typedef enum logic [1:0] {
        PET_ALIVE = 2'd0,
        PET_SICK  = 2'd1,
        PET_DEAD  = 2'd2
    } pet_state_e;

    // Clamps a signed stat sum into the legal range 0..max_val.
    function automatic int stat_sat_add(input int sum, input int max_val);
        int result;
        result = sum;
        if (sum < 0) begin
            result = 0;
        end else if (sum > max_val) begin
            result = max_val;
        end
        return result;
    endfunction

endpackage

// File: rtl/pet_stats_engine_if.sv
// Care-button / status bus between the switch inputs and the LED / 7-segment side.
interface pet_stats_engine_if #(
    parameter int unsigned NUM_STATS = 6,
    parameter int unsigned STAT_W    = 4
);
    logic [NUM_STATS-1:0]        care_i;
    logic                        revive_i;
    logic [NUM_STATS*STAT_W-1:0] stats_o;
    logic [NUM_STATS-1:0]        low_o;
    logic [1:0]                  state_o;
    logic                        tick_o;

    modport master (
        output care_i, revive_i,
        input  stats_o, low_o, state_o, tick_o
    );

    modport slave (
        input  care_i, revive_i,
        output stats_o, low_o, state_o, tick_o
    );
endinterface

// File: rtl/tick_prescaler.sv
// Decay-tick prescaler: one-cycle strobe each time the enabled count wraps to zero.
module tick_prescaler #(
    parameter logic [23:0] TICK_DIV = 24'd10_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ena,
    output logic tick_o
);
    logic [23:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_o <= 1'b0;
        end else if (ena) begin
            if (cnt_q == TICK_DIV - 24'd1) begin
                cnt_q  <= '0;
                tick_o <= 1'b1;
            end else begin
                cnt_q  <= cnt_q + 24'd1;
                tick_o <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/pet_stats_engine.sv
// Saturating pet care statistics with shared decay tick, edge-detected care
// buttons and an ALIVE/SICK/DEAD life-cycle FSM.
module pet_stats_engine
    import pet_pkg::*;
#(
    parameter int unsigned NUM_STATS   = 6,
    parameter int unsigned STAT_W      = 4,
    parameter logic [23:0] TICK_DIV    = 24'd10_000_000,
    parameter int unsigned CARE_STEP   = 3,
    parameter int unsigned LOW_THRESH  = 3,
    parameter int unsigned SICK_ZEROS  = 2,
    parameter int unsigned DEATH_TICKS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena,
    pet_stats_engine_if.slave bus
);
    localparam int          STAT_MAX = (1 << STAT_W) - 1;
    localparam int unsigned DW       = $clog2(DEATH_TICKS + 1);

    typedef logic signed [STAT_W+1:0] wide_t;

    logic                 tick;
    logic [NUM_STATS-1:0] care_q;
    logic [NUM_STATS-1:0] press;
    logic [NUM_STATS-1:0] is_zero;
    logic                 revive_q;
    logic                 revive_press;
    pet_state_e           state_q, state_d;
    logic [DW-1:0]        dcnt_q, dcnt_d;
    int unsigned          zeros;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .tick_o (tick)
    );

    assign press        = bus.care_i & ~care_q;
    assign revive_press = bus.revive_i & ~revive_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            care_q   <= '0;
            revive_q <= 1'b0;
        end else if (ena) begin
            care_q   <= bus.care_i;
            revive_q <= bus.revive_i;
        end
    end

    for (genvar i = 0; i < NUM_STATS; i++) begin : g_lane
        logic [STAT_W-1:0] stat_q, stat_d;
        logic              low_q;
        wide_t             sum;

        // Decay and care are summed in a widened signed value and clamped once,
        // so a coincident tick and press both apply even at the rails.
        always_comb begin
            sum = wide_t'({2'b00, stat_q});
            if (tick)     sum = sum - wide_t'(1);
            if (press[i]) sum = sum + wide_t'(CARE_STEP);
            stat_d = STAT_W'(stat_sat_add(int'(sum), STAT_MAX));
            if (state_q == PET_DEAD) stat_d = revive_press ? '1 : stat_q;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                stat_q <= '1;
                low_q  <= 1'b0;
            end else if (ena) begin
                stat_q <= stat_d;
                low_q  <= (32'(stat_q) < LOW_THRESH);
            end
        end

        assign bus.stats_o[i*STAT_W +: STAT_W] = stat_q;
        assign bus.low_o[i]                    = low_q;
        assign is_zero[i]                      = (stat_q == '0);
    end

    assign zeros = $countones(is_zero);

    // Recovery is tested before the death tick so it wins a same-cycle tie.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        case (state_q)
            PET_ALIVE: begin
                if (zeros >= SICK_ZEROS) state_d = PET_SICK;
            end
            PET_SICK: begin
                if (zeros < SICK_ZEROS) begin
                    state_d = PET_ALIVE;
                    dcnt_d  = '0;
                end else if (tick) begin
                    dcnt_d = dcnt_q + DW'(1);
                    if (dcnt_q == DW'(DEATH_TICKS - 1)) state_d = PET_DEAD;
                end
            end
            PET_DEAD: begin
                if (revive_press) begin
                    state_d = PET_ALIVE;
                    dcnt_d  = '0;
                end
            end
            default: begin
                state_d = PET_ALIVE;
                dcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= PET_ALIVE;
            dcnt_q  <= '0;
        end else if (ena) begin
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
        end
    end

    assign bus.state_o = state_q;
    assign bus.tick_o  = tick;
endmodule
